// File: rtl/skolem_xor_stream_if.sv
// Stream bundle for skolem_xor_stream: X input handshake and Y output handshake.
interface skolem_xor_stream_if #(
    parameter int unsigned NUM_IN  = 8,
    parameter int unsigned NUM_OUT = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [NUM_IN-1:0]  in_x;
    logic               out_valid;
    logic               out_ready;
    logic [NUM_OUT-1:0] out_y;

    modport master (
        output in_valid,
        output in_x,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_y
    );

    modport slave (
        input  in_valid,
        input  in_x,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_y
    );
endinterface

// File: rtl/skolem_xor_stream.sv
// Streaming Skolem generator for XOR-parity specs: folds parity(X) CHUNK bits per cycle and emits
// Y with parity(X)^parity(Y)==TARGET. Define SKOLEM_SELFCHECK_EN to add the output self-check.
module skolem_xor_stream #(
    parameter int unsigned NUM_IN  = 8,
    parameter int unsigned NUM_OUT = 8,
    parameter int unsigned CHUNK   = 4,
    parameter int unsigned TARGET  = 1,
    parameter int unsigned MODE    = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    skolem_xor_stream_if.slave bus,
    output logic               busy,
    output logic [CNT_W-1:0]   sample_cnt
`ifdef SKOLEM_SELFCHECK_EN
    ,
    output logic               chk_err,
    output logic [7:0]         err_cnt
`endif
);
    localparam int unsigned NCH   = (NUM_IN + CHUNK - 1) / CHUNK;
    localparam int unsigned PAD_W = NCH * CHUNK;
    localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NCH - 1);
    localparam logic [15:0]      LFSR_SEED = 16'hACE1;
    // Galois taps for x^16+x^14+x^13+x^11+1, right-shifting form
    localparam logic [15:0]      LFSR_TAPS = 16'hB400;
    localparam logic             TGT       = TARGET[0];

    typedef enum logic [1:0] {StIdle, StFold, StEmit} state_e;

    state_e             state_q;
    logic [PAD_W-1:0]   x_q;
    logic               acc_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NUM_OUT-1:0] out_y_q;
    logic               out_valid_q;
    logic               in_ready_q;
    logic               busy_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [15:0]        lfsr_q;

    logic [CHUNK-1:0]   chunk;
    logic               acc_fold;
    logic [NUM_OUT-2:0] free_bits;
    logic [NUM_OUT-1:0] y_fold;
    logic [15:0]        lfsr_next;

    // X is stored zero-padded to a whole number of chunks
    assign chunk     = x_q[idx_q * CHUNK +: CHUNK];
    assign acc_fold  = acc_q ^ (^chunk);
    assign free_bits = (MODE == 0) ? '1 : lfsr_q[NUM_OUT-2:0];
    assign y_fold    = {free_bits, TGT ^ acc_fold ^ (^free_bits)};
    assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

`ifdef SKOLEM_SELFCHECK_EN
    logic       chk_err_q;
    logic [7:0] err_cnt_q;
    logic       chk_par;

    // Recomputed from the stored X and the emitted Y, independent of acc_q
    assign chk_par = (^x_q) ^ (^out_y_q);
    assign chk_err = chk_err_q;
    assign err_cnt = err_cnt_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            x_q         <= '0;
            acc_q       <= 1'b0;
            idx_q       <= '0;
            out_y_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            lfsr_q      <= LFSR_SEED;
`ifdef SKOLEM_SELFCHECK_EN
            chk_err_q   <= 1'b0;
            err_cnt_q   <= 8'h00;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        x_q        <= PAD_W'(bus.in_x);
                        acc_q      <= 1'b0;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= StFold;
                    end
                end
                StFold: begin
                    acc_q <= acc_fold;
                    idx_q <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        out_y_q     <= y_fold;
                        out_valid_q <= 1'b1;
                        state_q     <= StEmit;
                    end
                end
                StEmit: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        cnt_q       <= cnt_q + 1'b1;
                        lfsr_q      <= lfsr_next;
                        state_q     <= StIdle;
`ifdef SKOLEM_SELFCHECK_EN
                        if (chk_par != TGT) begin
                            chk_err_q <= 1'b1;
                            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'h01;
                        end
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign busy          = busy_q;
    assign sample_cnt    = cnt_q;
endmodule

// File: tb/tb_skolem_xor_stream.sv
// Directed bench: dut_a is the default 8/8/4 MODE 0 build, dut_b is NUM_IN=10, MODE 1, CNT_W=4.
module tb_skolem_xor_stream;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    skolem_xor_stream_if #(.NUM_IN(8),  .NUM_OUT(8)) a ();
    skolem_xor_stream_if #(.NUM_IN(10), .NUM_OUT(8)) b ();

    logic        busy_a, busy_b;
    logic [15:0] cnt_a;
    logic [3:0]  cnt_b;
`ifdef SKOLEM_SELFCHECK_EN
    logic        chk_a, chk_b;
    logic [7:0]  ecnt_a, ecnt_b;
`endif

    skolem_xor_stream #(
        .NUM_IN(8), .NUM_OUT(8), .CHUNK(4), .TARGET(1), .MODE(0), .CNT_W(16)
    ) dut_a (
        .clk(clk), .rst(rst), .bus(a), .busy(busy_a), .sample_cnt(cnt_a)
`ifdef SKOLEM_SELFCHECK_EN
        , .chk_err(chk_a), .err_cnt(ecnt_a)
`endif
    );

    skolem_xor_stream #(
        .NUM_IN(10), .NUM_OUT(8), .CHUNK(4), .TARGET(1), .MODE(1), .CNT_W(4)
    ) dut_b (
        .clk(clk), .rst(rst), .bus(b), .busy(busy_b), .sample_cnt(cnt_b)
`ifdef SKOLEM_SELFCHECK_EN
        , .chk_err(chk_b), .err_cnt(ecnt_b)
`endif
    );

    logic [15:0] lfsr_m;
    logic [15:0] exp_cnt_a;
    logic [3:0]  exp_cnt_b;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
        logic [15:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ 16'hB400;
        return n;
    endfunction

    // Offer one X, wait (bounded) for Y, then allow one more edge for the output handshake.
    task automatic run_a(input logic [7:0] x, output logic [7:0] y, output int lat,
                         output logic rdy);
        @(negedge clk);
        rdy = a.in_ready;
        a.in_valid = 1'b1;
        a.in_x = x;
        @(negedge clk);
        a.in_valid = 1'b0;
        lat = 0;
        while (a.out_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        y = a.out_y;
        @(negedge clk);
    endtask

    task automatic run_b(input logic [9:0] x, output logic [7:0] y, output int lat,
                         output logic rdy);
        @(negedge clk);
        rdy = b.in_ready;
        b.in_valid = 1'b1;
        b.in_x = x;
        @(negedge clk);
        b.in_valid = 1'b0;
        lat = 0;
        while (b.out_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        y = b.out_y;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a.in_valid = 1'b0; a.in_x = '0; a.out_ready = 1'b1;
        b.in_valid = 1'b0; b.in_x = '0; b.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (a.in_ready !== 1'b1 || a.out_valid !== 1'b0 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL reset_a_ctrl: got rdy=%b vld=%b busy=%b want 1 0 0",
                     a.in_ready, a.out_valid, busy_a);
        end
        total++;
        if (a.out_y !== 8'h00 || cnt_a !== 16'h0000) begin
            bad++;
            $display("FAIL reset_a_data: got y=%h cnt=%h want 00 0000", a.out_y, cnt_a);
        end
        total++;
        if (b.in_ready !== 1'b1 || b.out_valid !== 1'b0 || busy_b !== 1'b0 ||
            b.out_y !== 8'h00 || cnt_b !== 4'h0) begin
            bad++;
            $display("FAIL reset_b: got rdy=%b vld=%b busy=%b y=%h cnt=%h want 1 0 0 00 0",
                     b.in_ready, b.out_valid, busy_b, b.out_y, cnt_b);
        end
        rst = 1'b0;
        lfsr_m = 16'hACE1;
        exp_cnt_a = 16'h0000;
        exp_cnt_b = 4'h0;
    endtask

    task automatic test_basic();
        logic [7:0] xs [3] = '{8'h00, 8'h01, 8'hFF};
        logic [7:0] ys [3] = '{8'hFE, 8'hFF, 8'hFE};
        logic [7:0] y;
        int lat;
        logic rdy;
        for (int i = 0; i < 3; i++) begin
            run_a(xs[i], y, lat, rdy);
            exp_cnt_a++;
            total++;
            if (y !== ys[i] || lat != 2 || rdy !== 1'b1) begin
                bad++;
                $display("FAIL basic_x%h: got y=%h lat=%0d rdy=%b want y=%h lat=2 rdy=1",
                         xs[i], y, lat, rdy, ys[i]);
            end
            total++;
            if (cnt_a !== exp_cnt_a || a.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL basic_cnt: got cnt=%0d rdy=%b want %0d 1", cnt_a, a.in_ready,
                         exp_cnt_a);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] y;
        int lat;
        logic rdy;
        int errs = 0;
        a.out_ready = 1'b0;
        run_a(8'h5A, y, lat, rdy);
        total++;
        if (y !== 8'hFE || lat != 2) begin
            bad++;
            $display("FAIL bp_first: got y=%h lat=%0d want FE 2", y, lat);
        end
        for (int i = 0; i < 20; i++) begin
            a.in_valid = i[0];
            a.in_x = 8'h01;
            @(negedge clk);
            if (a.out_y !== 8'hFE || a.out_valid !== 1'b1 || a.in_ready !== 1'b0 ||
                busy_a !== 1'b1) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL bp_hold: got %0d bad cycles want 0", errs);
        end
        a.in_valid = 1'b0;
        a.out_ready = 1'b1;
        @(negedge clk);
        exp_cnt_a++;
        total++;
        if (cnt_a !== exp_cnt_a || a.in_ready !== 1'b1 || a.out_valid !== 1'b0 ||
            busy_a !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: got cnt=%0d rdy=%b vld=%b busy=%b want %0d 1 0 0",
                     cnt_a, a.in_ready, a.out_valid, busy_a, exp_cnt_a);
        end
        run_a(8'h00, y, lat, rdy);
        exp_cnt_a++;
        total++;
        if (y !== 8'hFE || lat != 2 || rdy !== 1'b1) begin
            bad++;
            $display("FAIL bp_after: got y=%h lat=%0d rdy=%b want FE 2 1", y, lat, rdy);
        end
    endtask

    task automatic test_reset_mid_fold();
        logic [7:0] y;
        int lat;
        logic rdy;
        @(negedge clk);
        a.in_valid = 1'b1;
        a.in_x = 8'h01;
        @(negedge clk);
        a.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if (a.in_ready !== 1'b1 || a.out_valid !== 1'b0 || busy_a !== 1'b0 ||
            a.out_y !== 8'h00 || cnt_a !== 16'h0000) begin
            bad++;
            $display("FAIL midfold_rst: got rdy=%b vld=%b busy=%b y=%h cnt=%0d want 1 0 0 00 0",
                     a.in_ready, a.out_valid, busy_a, a.out_y, cnt_a);
        end
        @(negedge clk);
        rst = 1'b0;
        lfsr_m = 16'hACE1;
        exp_cnt_a = 16'h0000;
        exp_cnt_b = 4'h0;
        @(negedge clk);
        total++;
        if (a.out_valid !== 1'b0 || busy_a !== 1'b0) begin
            bad++;
            $display("FAIL midfold_idle: got vld=%b busy=%b want 0 0", a.out_valid, busy_a);
        end
        run_a(8'h01, y, lat, rdy);
        exp_cnt_a++;
        total++;
        if (y !== 8'hFF || lat != 2 || cnt_a !== exp_cnt_a) begin
            bad++;
            $display("FAIL midfold_next: got y=%h lat=%0d cnt=%0d want FF 2 %0d",
                     y, lat, cnt_a, exp_cnt_a);
        end
    endtask

    task automatic test_lfsr_wrap();
        // First three outputs with X=0 from seed ACE1, worked by hand
        logic [7:0] hand [3] = '{8'hC2, 8'hE0, 8'h70};
        logic [7:0] y, want;
        logic [9:0] x;
        int lat;
        logic rdy;
        for (int i = 0; i < 17; i++) begin
            x = (i < 3) ? 10'h000 : 10'(i * 37);
            want = (i < 3) ? hand[i]
                           : {lfsr_m[6:0], 1'b1 ^ (^x) ^ (^lfsr_m[6:0])};
            if (i == 5) b.out_ready = 1'b0;
            run_b(x, y, lat, rdy);
            if (i == 5) begin
                for (int k = 0; k < 6; k++) begin
                    b.in_valid = k[0];
                    @(negedge clk);
                end
                b.in_valid = 1'b0;
                b.out_ready = 1'b1;
                @(negedge clk);
            end
            lfsr_m = lfsr_adv(lfsr_m);
            exp_cnt_b++;
            total++;
            if (y !== want || lat != 3) begin
                bad++;
                $display("FAIL lfsr_y%0d: got y=%h lat=%0d want y=%h lat=3", i, y, lat, want);
            end
            total++;
            if (cnt_b !== exp_cnt_b) begin
                bad++;
                $display("FAIL wrap_cnt%0d: got %0d want %0d", i, cnt_b, exp_cnt_b);
            end
        end
    endtask

    task automatic test_padded();
        logic [7:0] y, want;
        int lat;
        logic rdy;
        want = {lfsr_m[6:0], 1'b1 ^ 1'b1 ^ (^lfsr_m[6:0])};
        run_b(10'h200, y, lat, rdy);
        lfsr_m = lfsr_adv(lfsr_m);
        exp_cnt_b++;
        total++;
        if (y !== want || lat != 3 || rdy !== 1'b1) begin
            bad++;
            $display("FAIL padded_200: got y=%h lat=%0d rdy=%b want %h 3 1", y, lat, rdy, want);
        end
        want = {lfsr_m[6:0], 1'b1 ^ (^lfsr_m[6:0])};
        run_b(10'h000, y, lat, rdy);
        lfsr_m = lfsr_adv(lfsr_m);
        exp_cnt_b++;
        total++;
        if (y !== want || lat != 3) begin
            bad++;
            $display("FAIL padded_000: got y=%h lat=%0d want %h 3", y, lat, want);
        end
    endtask

    task automatic test_random_parity();
        logic [7:0] y;
        logic [9:0] x;
        int lat;
        logic rdy;
        for (int i = 0; i < 1000; i++) begin
            x = 10'($urandom_range(0, 1023));
            run_b(x, y, lat, rdy);
            total++;
            if ((^{x, y}) !== 1'b1 || lat != 3) begin
                bad++;
                $display("FAIL rand_parity: x=%h got y=%h lat=%0d want parity 1 lat 3",
                         x, y, lat);
            end
            total++;
            if (y[7:1] !== lfsr_m[6:0]) begin
                bad++;
                $display("FAIL rand_free: x=%h got %h want %h", x, y[7:1], lfsr_m[6:0]);
            end
            lfsr_m = lfsr_adv(lfsr_m);
            exp_cnt_b++;
        end
        total++;
        if (cnt_b !== exp_cnt_b) begin
            bad++;
            $display("FAIL rand_cnt: got %0d want %0d", cnt_b, exp_cnt_b);
        end
    endtask

`ifdef SKOLEM_SELFCHECK_EN
    task automatic test_selfcheck();
        int lat = 0;
        total++;
        if (chk_a !== 1'b0 || ecnt_a !== 8'h00 || chk_b !== 1'b0) begin
            bad++;
            $display("FAIL chk_clean: got a=%b/%0d b=%b want 0/0 0", chk_a, ecnt_a, chk_b);
        end
        @(negedge clk);
        a.in_valid = 1'b1;
        a.in_x = 8'h00;
        @(negedge clk);
        a.in_valid = 1'b0;
        dut_a.acc_q = ~dut_a.acc_q;
        while (a.out_valid !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (a.out_y !== 8'hFF) begin
            bad++;
            $display("FAIL chk_corrupt_y: got %h want FF", a.out_y);
        end
        @(negedge clk);
        total++;
        if (chk_a !== 1'b1 || ecnt_a !== 8'h01) begin
            bad++;
            $display("FAIL chk_flag: got %b/%0d want 1/1", chk_a, ecnt_a);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid_fold();
        test_lfsr_wrap();
        test_padded();
        test_random_parity();
`ifdef SKOLEM_SELFCHECK_EN
        test_selfcheck();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
